breathe_led_array: RTL and testbench

BREATHE_LED_ARRAY -- requirements
Module: breathe_led_array

---
 rtl/breathe_led_array.sv | 98 +++++++++
 tb/tb_breathe_led_array.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breathe_led_array.sv
// Multi-channel LED driver: each channel is off, on, breathing (PWM triangle ramp) or blinking.
// Every channel keeps its own tick divider, PWM frame counter and duty ramp. The channels share only sync and reset.
module breathe_led_array #(
  parameter int CH_NUM         = 3,
  parameter int DIV_W          = 7,
  parameter int PWM_MAX        = 1000,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      sync,
  input  logic [2*CH_NUM-1:0]       mode,
  input  logic [DIV_W*CH_NUM-1:0]   div,
  output logic [CH_NUM-1:0]         led,
  output logic [CH_NUM-1:0]         cycle_done
);

  localparam logic [9:0] PWM_LAST = 10'(PWM_MAX - 1);
  localparam logic       LED_DARK = (LED_ACTIVE_LOW != 0);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] div_last;
    logic [DIV_W-1:0] cnt_tick;
    logic [9:0]       cnt_pwm;
    logic [9:0]       cnt_duty;
    logic [9:0]       level;
    logic [1:0]       mode_c;
    logic             dir;
    logic             tick;
    logic             pwm_wrap;
    logic             duty_wrap;
    logic             pwm_on;
    logic             raw;
    logic             led_q;
    logic             done_q;

    assign div_c  = div[c*DIV_W +: DIV_W];
    assign mode_c = mode[2*c +: 2];

    // A divider of zero acts as one. The >= compare makes a lowered divider wrap on the next cycle.
    assign div_last  = (div_c == '0) ? '0 : div_c - 1'b1;
    assign tick      = (cnt_tick >= div_last);
    assign pwm_wrap  = tick && (cnt_pwm == PWM_LAST);
    assign duty_wrap = pwm_wrap && (cnt_duty == PWM_LAST);

    assign level  = dir ? (PWM_LAST - cnt_duty) : cnt_duty;
    assign pwm_on = (cnt_pwm < level);

    always_comb begin
      // NOTE: default assignment first so no path through the case leaves raw unassigned (no latch).
      raw = 1'b0;
      case (mode_c)
        MODE_OFF:     raw = 1'b0;
        MODE_ON:      raw = 1'b1;
        MODE_BREATHE: raw = pwm_on;
        MODE_BLINK:   raw = ~dir;
        default:      raw = 1'b0;
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_tick <= '0;
        cnt_pwm  <= '0;
        cnt_duty <= '0;
        dir      <= 1'b0;
        // NOTE: the LED output resets to its dark level, which depends on polarity, rather than to 0.
        led_q    <= LED_DARK;
        done_q   <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments. Every register here samples the pre-edge state.
        led_q  <= raw ^ LED_DARK;
        done_q <= duty_wrap && dir && mode_c[1] && !sync;
        if (sync) begin
          cnt_tick <= '0;
          cnt_pwm  <= '0;
          cnt_duty <= '0;
          dir      <= 1'b0;
        end else begin
          cnt_tick <= tick ? '0 : cnt_tick + 1'b1;
          if (tick)      cnt_pwm  <= pwm_wrap ? '0 : cnt_pwm + 10'd1;
          if (pwm_wrap)  cnt_duty <= duty_wrap ? '0 : cnt_duty + 10'd1;
          if (duty_wrap) dir      <= ~dir;
        end
      end
    end

    assign led[c]        = led_q;
    assign cycle_done[c] = done_q;
  end

endmodule

// File: tb/tb_breathe_led_array.sv
// Self-checking bench for breathe_led_array. Two instances (normal and inverted LED polarity) share the stimulus.
// A tick-position reference model supplies the expected value for every cycle.
module tb_breathe_led_array;

  localparam int CH = 2;
  localparam int DW = 7;
  localparam int PM = 4;
  localparam int FULL = 2 * PM * PM;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              sync      = 1'b0;
  logic [2*CH-1:0]   mode      = '0;
  logic [DW*CH-1:0]  div       = '0;
  logic [CH-1:0]     led, led_inv, cd, cd_inv;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: ticks elapsed within one full up+down cycle, and cycles since the last tick.
  int            m_pos  [CH];
  int            m_tick [CH];
  logic [CH-1:0] exp_led = '0;
  logic [CH-1:0] exp_cd  = '0;

  int hc_want [8] = '{0, 1, 2, 3, 3, 2, 1, 0};

  breathe_led_array #(.CH_NUM(CH), .DIV_W(DW), .PWM_MAX(PM), .LED_ACTIVE_LOW(0)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sync(sync), .mode(mode), .div(div),
    .led(led), .cycle_done(cd));

  breathe_led_array #(.CH_NUM(CH), .DIV_W(DW), .PWM_MAX(PM), .LED_ACTIVE_LOW(1)) dut_inv (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sync(sync), .mode(mode), .div(div),
    .led(led_inv), .cycle_done(cd_inv));

  always #5 sys_clk = ~sys_clk;

  // Duty, frame position and direction all follow from the elapsed tick count.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_pos[c]  = 0;
        m_tick[c] = 0;
      end
      exp_led = '0;
      exp_cd  = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        int d, m, pwm, duty, falling, lvl;
        bit raw, tk;
        d = int'(div[c*DW +: DW]);
        if (d == 0) d = 1;
        m       = int'(mode[2*c +: 2]);
        pwm     = m_pos[c] % PM;
        duty    = (m_pos[c] / PM) % PM;
        falling = m_pos[c] / (PM * PM);
        lvl     = (falling != 0) ? (PM - 1 - duty) : duty;
        case (m)
          0:       raw = 1'b0;
          1:       raw = 1'b1;
          2:       raw = (pwm < lvl);
          default: raw = (falling == 0);
        endcase
        exp_led[c] = raw;
        exp_cd[c]  = 1'b0;
        if (sync) begin
          m_pos[c]  = 0;
          m_tick[c] = 0;
        end else begin
          tk = (m_tick[c] >= d - 1);
          m_tick[c] = tk ? 0 : m_tick[c] + 1;
          if (tk) begin
            m_pos[c]  = (m_pos[c] + 1) % FULL;
            exp_cd[c] = (m_pos[c] == 0) && (m >= 2);
          end
        end
      end
    end
  end

  task automatic set_ch(input int c, input int m, input int d);
    mode[2*c +: 2]  = 2'(m);
    div[c*DW +: DW] = DW'(d);
  endtask

  // Called just after a falling edge. Returns at the falling edge that follows the sync edge.
  task automatic apply_sync();
    sync = 1'b1;
    @(negedge sys_clk);
    sync = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      n_tests++;
      if ({led, led_inv, cd, cd_inv} !== {2'b00, 2'b11, 2'b00, 2'b00}) begin
        n_fail++;
        $display("FAIL reset: led=%b led_inv=%b cd=%b cd_inv=%b, want 00 11 00 00", led, led_inv, cd, cd_inv);
      end
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_breathe();
    int hc [8];
    logic [1:0] want_cd;
    for (int f = 0; f < 8; f++) hc[f] = 0;
    set_ch(0, 2, 1);
    set_ch(1, 2, 2);
    apply_sync();
    for (int i = 1; i <= 130; i++) begin
      @(negedge sys_clk);
      want_cd = {(i % 64) == 0, (i % 32) == 0};
      n_tests++;
      if (cd !== want_cd || cd_inv !== want_cd) begin
        n_fail++;
        $display("FAIL breathe cycle_done @%0d: got %b/%b want %b", i, cd, cd_inv, want_cd);
      end
      n_tests++;
      if (led !== exp_led || led_inv !== ~exp_led) begin
        n_fail++;
        $display("FAIL breathe led @%0d: got %b/%b want %b", i, led, led_inv, exp_led);
      end
      if (i <= 32 && led[0]) hc[(i - 1) / 4]++;
    end
    for (int f = 0; f < 8; f++) begin
      n_tests++;
      if (hc[f] !== hc_want[f]) begin
        n_fail++;
        $display("FAIL breathe frame %0d high count: got %0d want %0d", f, hc[f], hc_want[f]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [1:0] want_cd;
    set_ch(0, 2, 0);
    set_ch(1, 2, 1);
    apply_sync();
    for (int i = 1; i <= 80; i++) begin
      @(negedge sys_clk);
      want_cd = {(i % 32) == 0, (i % 32) == 0};
      n_tests++;
      if (cd !== want_cd || led !== exp_led || led_inv !== ~exp_led) begin
        n_fail++;
        $display("FAIL div_zero @%0d: cd=%b led=%b led_inv=%b want cd=%b led=%b", i, cd, led, led_inv, want_cd, exp_led);
      end
    end
  endtask

  task automatic test_modes();
    logic [1:0] want;
    set_ch(0, 1, 1);
    set_ch(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 2'b01 || led_inv !== 2'b10) begin
        n_fail++;
        $display("FAIL modes on/off: led=%b led_inv=%b want 01 10", led, led_inv);
      end
    end
    set_ch(0, 0, 1);
    set_ch(1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 2'b10 || led_inv !== 2'b01) begin
        n_fail++;
        $display("FAIL modes off/on: led=%b led_inv=%b want 10 01", led, led_inv);
      end
    end
    set_ch(0, 3, 1);
    apply_sync();
    for (int i = 1; i <= 64; i++) begin
      @(negedge sys_clk);
      want = {1'b1, (((i - 1) / 16) % 2) == 0};
      n_tests++;
      if (led !== want || led_inv !== ~want) begin
        n_fail++;
        $display("FAIL modes blink @%0d: led=%b led_inv=%b want %b", i, led, led_inv, want);
      end
    end
  endtask

  task automatic test_sync_phase();
    logic [1:0] want;
    set_ch(0, 2, 1);
    set_ch(1, 2, 3);
    apply_sync();
    repeat (31) @(negedge sys_clk);
    // Channel 0 would wrap on this edge; sync must swallow the pulse.
    apply_sync();
    n_tests++;
    if (cd !== 2'b00 || cd_inv !== 2'b00 || exp_cd !== 2'b00) begin
      n_fail++;
      $display("FAIL sync cycle_done: cd=%b cd_inv=%b model=%b want 00", cd, cd_inv, exp_cd);
    end
    set_ch(0, 3, 1);
    set_ch(1, 3, 1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge sys_clk);
      want = ((((i - 1) / 16) % 2) == 0) ? 2'b11 : 2'b00;
      n_tests++;
      if (led !== want || led_inv !== ~want || led !== exp_led) begin
        n_fail++;
        $display("FAIL sync aligned @%0d: led=%b led_inv=%b want %b", i, led, led_inv, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] want;
    set_ch(0, 1, 1);
    set_ch(1, 2, 2);
    apply_sync();
    repeat (13) @(negedge sys_clk);
    n_tests++;
    if (led[0] !== 1'b1 || led_inv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async pre-reset: led=%b led_inv=%b want ch0 lit", led, led_inv);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({led, led_inv, cd, cd_inv} !== {2'b00, 2'b11, 2'b00, 2'b00}) begin
      n_fail++;
      $display("FAIL async reset immediate: led=%b led_inv=%b cd=%b, want 00 11 00", led, led_inv, cd);
    end
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (led !== 2'b00 || led_inv !== 2'b11) begin
      n_fail++;
      $display("FAIL async reset held: led=%b led_inv=%b want 00 11", led, led_inv);
    end
    sys_rst_n = 1'b1;
    set_ch(0, 3, 1);
    set_ch(1, 3, 1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge sys_clk);
      want = (i <= 16) ? 2'b11 : 2'b00;
      n_tests++;
      if (led !== want || led_inv !== ~want || cd !== 2'b00) begin
        n_fail++;
        $display("FAIL async restart @%0d: led=%b led_inv=%b cd=%b want %b cd 00", i, led, led_inv, cd, want);
      end
    end
  endtask

  task automatic test_div_change();
    set_ch(0, 2, 5);
    set_ch(1, 0, 0);
    apply_sync();
    repeat (3) @(negedge sys_clk);
    set_ch(0, 2, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge sys_clk);
      n_tests++;
      if (cd[0] !== (k == 32) || cd_inv[0] !== (k == 32)) begin
        n_fail++;
        $display("FAIL div_change cycle_done @%0d: got %b want %b", k, cd[0], (k == 32));
      end
      n_tests++;
      if (led !== exp_led || led_inv !== ~exp_led) begin
        n_fail++;
        $display("FAIL div_change led @%0d: got %b want %b", k, led, exp_led);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge sys_clk);
      n_tests++;
      if ({led, led_inv, cd, cd_inv} !== {exp_led, ~exp_led, exp_cd, exp_cd}) begin
        n_fail++;
        $display("FAIL random @%0d: led=%b led_inv=%b cd=%b cd_inv=%b want led=%b cd=%b",
                 i, led, led_inv, cd, cd_inv, exp_led, exp_cd);
      end
      if ($urandom_range(0, 39) == 0)
        set_ch(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      sync = ($urandom_range(0, 199) == 0);
    end
    sync = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_breathe();
    test_div_zero();
    test_modes();
    test_sync_phase();
    test_async_reset();
    test_div_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
